// File: rtl/rat_int_ctrl_pkg.sv
// Shared types and constants for the RAT interrupt controller.
// Holds the FSM state encoding, the register offsets and the fixed-priority selector.
package rat_int_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_SERVICE = 2'd2
    } st_e;

    localparam logic [1:0] OFS_MASK = 2'd0;
    localparam logic [1:0] OFS_PEND = 2'd1;
    localparam logic [1:0] OFS_ID   = 2'd2;

    localparam int ID_W = 3;

    // Index 0 wins: scan from the top so the lowest set bit is written last.
    function automatic logic [ID_W-1:0] lowest_set(input logic [7:0] v);
        lowest_set = '0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) lowest_set = ID_W'(i);
        end
    endfunction

endpackage

// File: rtl/rat_int_ctrl_if.sv
// CPU-side bus of the interrupt controller: INT/INT_ACK request pair plus the RAT I/O port.
// IO_STRB qualifies PORT_ID/OUT_PORT for exactly one cycle and is always accepted; INT stays
// high until the control unit returns a one-cycle INT_ACK (or the request is withdrawn).
interface rat_int_if;
    logic       INT;
    logic       INT_ACK;
    logic       IO_STRB;
    logic [7:0] PORT_ID;
    logic [7:0] OUT_PORT;
    logic [7:0] RD_DATA;
    logic       RD_HIT;

    modport master (
        input  INT, RD_DATA, RD_HIT,
        output INT_ACK, IO_STRB, PORT_ID, OUT_PORT
    );

    modport slave (
        output INT, RD_DATA, RD_HIT,
        input  INT_ACK, IO_STRB, PORT_ID, OUT_PORT
    );
endinterface

// File: rtl/rat_irq_edge.sv
// Per-bit synchroniser chain followed by a rising-edge detector.
// edge_o is high for one cycle when the synchronised input goes 0 -> 1.
module rat_irq_edge #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] edge_o
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_d [SYNC_STAGES];
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] prev_d;

    always_comb begin
        sync_d[0] = async_i;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            prev_q <= '0;
        end else begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_d[s];
            end
            prev_q <= prev_d;
        end
    end

    assign edge_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/rat_int_ctrl.sv
// Fixed-priority interrupt controller presenting one request at a time on the RAT INT line.
// Sources latch as pending on a rising edge; the ID is held from acknowledge until EOI.
module rat_int_ctrl
    import rat_int_pkg::*;
#(
    parameter int         N_SRC       = 8,
    parameter logic [7:0] BASE_PORT   = 8'h20,
    parameter int         SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [N_SRC-1:0] IRQ,
    rat_int_if.slave         bus,
    output st_e              dbg_state
);

    localparam logic [8:0] SRC_MASK_W = (9'd1 << N_SRC) - 9'd1;
    localparam logic [7:0] SRC_MASK   = SRC_MASK_W[7:0];

    logic [N_SRC-1:0] irq_edge;
    logic [7:0]       edge_vec;

    rat_irq_edge #(
        .WIDTH       (N_SRC),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge (
        .clk     (CLK),
        .rst     (RESET),
        .async_i (IRQ),
        .edge_o  (irq_edge)
    );

    always_comb begin
        edge_vec = '0;
        edge_vec[N_SRC-1:0] = irq_edge;
    end

    st_e             state_q, state_d;
    logic            int_q, int_d;
    logic            active_q, active_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [7:0]      mask_q, mask_d;
    logic [7:0]      pend_q, pend_d;

    // Offset arithmetic wraps, so anything below BASE_PORT lands far above 2.
    logic [7:0] ofs;
    logic       hit;
    logic       wr_mask, wr_pend, wr_id;

    assign ofs     = bus.PORT_ID - BASE_PORT;
    assign hit     = (ofs < 8'd3);
    assign wr_mask = bus.IO_STRB && hit && (ofs[1:0] == OFS_MASK);
    assign wr_pend = bus.IO_STRB && hit && (ofs[1:0] == OFS_PEND);
    assign wr_id   = bus.IO_STRB && hit && (ofs[1:0] == OFS_ID);

    logic [7:0] eligible;
    logic [7:0] w1c_clr;
    logic [7:0] ack_clr;

    assign eligible = pend_q & mask_q;
    assign w1c_clr  = wr_pend ? bus.OUT_PORT : 8'h00;

    always_comb begin
        state_d  = state_q;
        int_d    = int_q;
        id_d     = id_q;
        active_d = active_q;
        mask_d   = wr_mask ? (bus.OUT_PORT & SRC_MASK) : mask_q;
        ack_clr  = '0;

        unique case (state_q)
            ST_IDLE: begin
                int_d = 1'b0;
                if (eligible != 8'h00) begin
                    id_d    = lowest_set(eligible);
                    state_d = ST_ASSERT;
                    int_d   = 1'b1;
                end
            end
            ST_ASSERT: begin
                if (bus.INT_ACK) begin
                    ack_clr[id_q] = 1'b1;
                    active_d      = 1'b1;
                    state_d       = ST_SERVICE;
                    int_d         = 1'b0;
                end else if (!eligible[id_q]) begin
                    state_d = ST_IDLE;
                    int_d   = 1'b0;
                end
            end
            ST_SERVICE: begin
                int_d = 1'b0;
                if (wr_id) begin
                    active_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                int_d    = 1'b0;
                active_d = 1'b0;
            end
        endcase

        // A fresh edge outranks any clear landing in the same cycle.
        pend_d = ((pend_q & ~w1c_clr & ~ack_clr) | edge_vec) & SRC_MASK;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            int_q    <= 1'b0;
            id_q     <= '0;
            active_q <= 1'b0;
            mask_q   <= '0;
            pend_q   <= '0;
        end else begin
            state_q  <= state_d;
            int_q    <= int_d;
            id_q     <= id_d;
            active_q <= active_d;
            mask_q   <= mask_d;
            pend_q   <= pend_d;
        end
    end

    always_comb begin
        bus.RD_DATA = 8'h00;
        if (hit) begin
            unique case (ofs[1:0])
                OFS_MASK: bus.RD_DATA = mask_q;
                OFS_PEND: bus.RD_DATA = pend_q;
                OFS_ID:   bus.RD_DATA = {active_q, 4'b0000, id_q};
                default:  bus.RD_DATA = 8'h00;
            endcase
        end
    end

    assign bus.RD_HIT = hit;
    assign bus.INT    = int_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_rat_int_ctrl.sv
// Directed walk through the controller's scenarios, then randomized rounds checked against
// a set-based model of pending sources and fixed-priority service order.
module tb_rat_int_ctrl;
    import rat_int_pkg::*;

    localparam logic [7:0] P_MASK = 8'h20;
    localparam logic [7:0] P_PEND = 8'h21;
    localparam logic [7:0] P_ID   = 8'h22;

    logic       CLK;
    logic       RESET;
    logic [7:0] IRQ;
    st_e        dbg_state;

    int total = 0;
    int bad   = 0;

    rat_int_if bus_if ();

    rat_int_ctrl #(
        .N_SRC       (8),
        .BASE_PORT   (8'h20),
        .SYNC_STAGES (2)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .IRQ       (IRQ),
        .bus       (bus_if.slave),
        .dbg_state (dbg_state)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [7:0] p, output logic [7:0] d);
        bus_if.PORT_ID = p;
        #1;
        d = bus_if.RD_DATA;
    endtask

    task automatic chk_rd(input string tag, input logic [7:0] p, input logic [7:0] exp);
        logic [7:0] d;
        rd(p, d);
        chk(tag, {24'h0, d}, {24'h0, exp});
    endtask

    task automatic wr(input logic [7:0] p, input logic [7:0] d);
        bus_if.PORT_ID  = p;
        bus_if.OUT_PORT = d;
        bus_if.IO_STRB  = 1'b1;
        tick();
        bus_if.IO_STRB  = 1'b0;
    endtask

    task automatic ack();
        bus_if.INT_ACK = 1'b1;
        tick();
        bus_if.INT_ACK = 1'b0;
    endtask

    function automatic int lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    initial begin
        logic [7:0] m_mask;
        logic [7:0] m_pend;
        logic [7:0] s_raise;
        int         w;

        RESET = 1'b1;
        IRQ   = 8'h00;
        bus_if.INT_ACK  = 1'b0;
        bus_if.IO_STRB  = 1'b0;
        bus_if.PORT_ID  = 8'h00;
        bus_if.OUT_PORT = 8'h00;
        tick(); tick(); tick();
        RESET = 1'b0;

        chk("rst_int", {31'h0, bus_if.INT}, 32'h0);
        chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        chk_rd("rst_mask", P_MASK, 8'h00);
        chk_rd("rst_pend", P_PEND, 8'h00);
        chk_rd("rst_id", P_ID, 8'h00);

        // 1: single source through the full request/ack/EOI cycle
        wr(P_MASK, 8'h04);
        IRQ = 8'h04;
        tick(); tick();
        chk_rd("t1_pend_early", P_PEND, 8'h00);
        tick();
        chk_rd("t1_pend", P_PEND, 8'h04);
        chk("t1_int_early", {31'h0, bus_if.INT}, 32'h0);
        tick();
        chk("t1_int", {31'h0, bus_if.INT}, 32'h1);
        chk("t1_state_assert", 32'(dbg_state), 32'(ST_ASSERT));
        tick();
        ack();
        IRQ = 8'h00;
        chk("t1_int_after_ack", {31'h0, bus_if.INT}, 32'h0);
        chk_rd("t1_pend_after_ack", P_PEND, 8'h00);
        chk_rd("t1_id_active", P_ID, 8'h82);
        wr(P_ID, 8'h00);
        chk_rd("t1_id_eoi", P_ID, 8'h02);
        chk("t1_state_idle", 32'(dbg_state), 32'(ST_IDLE));

        // 2: two simultaneous sources, lower index served first
        wr(P_MASK, 8'hFF);
        IRQ = 8'h22;
        tick(); tick(); tick(); tick();
        chk("t2_int", {31'h0, bus_if.INT}, 32'h1);
        chk_rd("t2_id1", P_ID, 8'h01);
        ack();
        chk_rd("t2_id1_active", P_ID, 8'h81);
        chk_rd("t2_pend", P_PEND, 8'h20);
        wr(P_ID, 8'h00);
        chk("t2_int_gap", {31'h0, bus_if.INT}, 32'h0);
        tick();
        chk("t2_int_re", {31'h0, bus_if.INT}, 32'h1);
        chk_rd("t2_id5", P_ID, 8'h05);
        ack();
        wr(P_ID, 8'h00);
        IRQ = 8'h00;
        tick(); tick(); tick();
        chk("t2_int_done", {31'h0, bus_if.INT}, 32'h0);

        // 3: masking during ASSERT withdraws the request
        wr(P_MASK, 8'h08);
        IRQ = 8'h08;
        tick(); tick(); tick(); tick();
        chk("t3_int", {31'h0, bus_if.INT}, 32'h1);
        wr(P_MASK, 8'h00);
        tick();
        chk("t3_int_withdrawn", {31'h0, bus_if.INT}, 32'h0);
        chk("t3_state_idle", 32'(dbg_state), 32'(ST_IDLE));
        chk_rd("t3_pend", P_PEND, 8'h08);
        wr(P_MASK, 8'h08);
        tick();
        chk("t3_int_re", {31'h0, bus_if.INT}, 32'h1);
        chk_rd("t3_id", P_ID, 8'h03);
        ack();
        wr(P_ID, 8'h00);
        IRQ = 8'h00;

        // 4: edge and W1C in the same cycle, set wins
        wr(P_MASK, 8'h00);
        IRQ = 8'h01;
        tick(); tick();
        wr(P_PEND, 8'h01);
        chk_rd("t4_pend_set_wins", P_PEND, 8'h01);
        wr(P_PEND, 8'h01);
        chk_rd("t4_pend_cleared", P_PEND, 8'h00);
        tick();
        chk("t4_no_int", {31'h0, bus_if.INT}, 32'h0);
        IRQ = 8'h00;
        tick(); tick(); tick();

        // 5: new source during SERVICE waits until EOI
        wr(P_MASK, 8'h11);
        IRQ = 8'h10;
        tick(); tick(); tick(); tick();
        chk("t5_int", {31'h0, bus_if.INT}, 32'h1);
        ack();
        chk_rd("t5_id4", P_ID, 8'h84);
        IRQ = 8'h11;
        tick(); tick(); tick(); tick();
        chk("t5_int_service", {31'h0, bus_if.INT}, 32'h0);
        chk_rd("t5_pend", P_PEND, 8'h01);
        chk("t5_state", 32'(dbg_state), 32'(ST_SERVICE));
        wr(P_ID, 8'h00);
        tick();
        chk("t5_int_after_eoi", {31'h0, bus_if.INT}, 32'h1);
        chk_rd("t5_id0", P_ID, 8'h00);
        ack();
        wr(P_ID, 8'h00);
        IRQ = 8'h00;
        tick(); tick(); tick();

        // 6: reset while a request is asserted
        wr(P_MASK, 8'hFF);
        IRQ = 8'h10;
        tick(); tick(); tick(); tick();
        chk("t6_int", {31'h0, bus_if.INT}, 32'h1);
        chk_rd("t6_pend", P_PEND, 8'h10);
        RESET = 1'b1;
        IRQ   = 8'h00;
        tick();
        RESET = 1'b0;
        chk("t6_int_reset", {31'h0, bus_if.INT}, 32'h0);
        chk("t6_state", 32'(dbg_state), 32'(ST_IDLE));
        chk_rd("t6_mask", P_MASK, 8'h00);
        chk_rd("t6_pend0", P_PEND, 8'h00);
        chk_rd("t6_id", P_ID, 8'h00);
        bus_if.PORT_ID = 8'h23;
        #1;
        chk("t6_hit_23", {31'h0, bus_if.RD_HIT}, 32'h0);
        chk("t6_data_23", {24'h0, bus_if.RD_DATA}, 32'h0);
        bus_if.PORT_ID = 8'h1F;
        #1;
        chk("t6_hit_1f", {31'h0, bus_if.RD_HIT}, 32'h0);
        bus_if.PORT_ID = 8'h20;
        #1;
        chk("t6_hit_20", {31'h0, bus_if.RD_HIT}, 32'h1);
        tick(); tick(); tick();

        // Randomized rounds: model pending as a set, serve by lowest eligible index
        m_pend = 8'h00;
        for (int r = 0; r < 24; r++) begin
            m_mask  = 8'($urandom_range(0, 255));
            s_raise = 8'($urandom_range(1, 255));
            wr(P_MASK, m_mask);
            IRQ = s_raise;
            tick(); tick(); tick(); tick();
            m_pend = m_pend | s_raise;
            chk_rd("rnd_pend", P_PEND, m_pend);
            chk_rd("rnd_mask", P_MASK, m_mask);
            for (int k = 0; k < 8; k++) begin
                if ((m_pend & m_mask) != 8'h00) begin
                    w = lowest(m_pend & m_mask);
                    chk("rnd_int", {31'h0, bus_if.INT}, 32'h1);
                    chk_rd("rnd_id", P_ID, 8'(w));
                    ack();
                    m_pend[w] = 1'b0;
                    chk("rnd_int_ack", {31'h0, bus_if.INT}, 32'h0);
                    chk_rd("rnd_id_active", P_ID, 8'h80 | 8'(w));
                    chk_rd("rnd_pend_ack", P_PEND, m_pend);
                    wr(P_ID, 8'h00);
                    tick();
                end
            end
            chk("rnd_int_idle", {31'h0, bus_if.INT}, 32'h0);
            wr(P_PEND, 8'hFF);
            m_pend = 8'h00;
            chk_rd("rnd_pend_clr", P_PEND, m_pend);
            IRQ = 8'h00;
            tick(); tick(); tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
